// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Multiplies by shift-add and divides by restoring division, one bit per cycle
// over 32 cycles. Divide by zero and signed overflow finish in a single cycle.
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous reset, active-high (asserted = 1)
//   start     request, sampled only while idle
//   op        funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   rs1_data  dividend / multiplicand
//   rs2_data  divisor / multiplier
//   rd_in     destination register index
//   busy      high while an operation is in flight (core stall)
//   done      one-cycle pulse, result valid
//   result    registered result, held until the next done
//   rd_out    latched destination index
//   wb_en     register file write enable (done and rd_out != 0)
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        wb_en
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned PLEN  = 2 * XLEN;
  localparam int unsigned CNT_W = 5;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] count_q, count_n;
  logic [2:0]       op_q, op_n;
  logic             neg_q, neg_n;
  logic [PLEN-1:0]  acc_q, acc_n;
  logic [PLEN-1:0]  mcand_q, mcand_n;
  logic [XLEN-1:0]  mplier_q, mplier_n;
  logic [XLEN:0]    rem_q, rem_n;
  logic [XLEN-1:0]  quo_q, quo_n;
  logic [XLEN-1:0]  dvsr_q, dvsr_n;
  logic [XLEN-1:0]  result_n;
  logic [4:0]       rd_n;
  logic             busy_n, done_n, wb_en_n;

  // Operand decode for the request presented in IDLE
  logic            rs1_signed, rs2_signed, neg1, neg2;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] fast_result;

  // One iteration of each datapath
  logic [PLEN-1:0]  acc_step, prod_fin;
  logic [XLEN+1:0]  trial;
  logic [XLEN:0]    rem_step;
  logic [XLEN-1:0]  quo_step, quo_fin, rem_fin;

  always_comb begin
    rs1_signed  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    rs2_signed  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    neg1        = rs1_signed && rs1_data[XLEN-1];
    neg2        = rs2_signed && rs2_data[XLEN-1];
    mag1        = neg1 ? -rs1_data : rs1_data;
    mag2        = neg2 ? -rs2_data : rs2_data;
    div_zero    = op[2] && (rs2_data == '0);
    div_ovf     = op[2] && !op[0] && (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
    if (div_zero) fast_result = op[1] ? rs1_data : 32'hFFFF_FFFF;
    else          fast_result = op[1] ? 32'h0000_0000 : 32'h8000_0000;
  end

  // Shift-add step and restoring-division step, plus sign fix-up of the final values
  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    prod_fin = neg_q ? -acc_step : acc_step;
    // Partial remainder shifted left with the next dividend bit; bit 33 is the borrow
    trial    = {rem_q, quo_q[XLEN-1]} - {2'b00, dvsr_q};
    rem_step = trial[XLEN+1] ? {rem_q[XLEN-1:0], quo_q[XLEN-1]} : trial[XLEN:0];
    quo_step = {quo_q[XLEN-2:0], ~trial[XLEN+1]};
    quo_fin  = neg_q ? -quo_step : quo_step;
    rem_fin  = neg_q ? -rem_step[XLEN-1:0] : rem_step[XLEN-1:0];
  end

  // Next-state, datapath and output logic
  always_comb begin
    state_n  = state_q;
    count_n  = count_q;
    op_n     = op_q;
    neg_n    = neg_q;
    acc_n    = acc_q;
    mcand_n  = mcand_q;
    mplier_n = mplier_q;
    rem_n    = rem_q;
    quo_n    = quo_q;
    dvsr_n   = dvsr_q;
    result_n = result;
    rd_n     = rd_out;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_n     = op;
          rd_n     = rd_in;
          neg_n    = (op == OP_REM) ? neg1 : (neg1 ^ neg2);
          count_n  = '0;
          acc_n    = '0;
          mcand_n  = {{XLEN{1'b0}}, mag1};
          mplier_n = mag2;
          rem_n    = '0;
          quo_n    = mag1;
          dvsr_n   = mag2;
          if (div_zero || div_ovf) begin
            result_n = fast_result;
            state_n  = S_DONE;
          end else begin
            state_n  = S_CALC;
          end
        end
      end
      S_CALC: begin
        count_n  = count_q + CNT_W'(1);
        acc_n    = acc_step;
        mcand_n  = {mcand_q[PLEN-2:0], 1'b0};
        mplier_n = {1'b0, mplier_q[XLEN-1:1]};
        rem_n    = rem_step;
        quo_n    = quo_step;
        if (count_q == CNT_W'(XLEN - 1)) begin
          state_n = S_DONE;
          unique case (op_q)
            OP_MUL:                       result_n = prod_fin[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_n = prod_fin[PLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result_n = quo_fin;
            OP_REM, OP_REMU:              result_n = rem_fin;
            default:                      result_n = result;
          endcase
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    busy_n  = (state_n != S_IDLE);
    done_n  = (state_n == S_DONE);
    wb_en_n = (state_n == S_DONE) && (rd_n != '0);
  end

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= S_IDLE;
    else       state_q <= state_n;
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      count_q  <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      result   <= '0;
      rd_out   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wb_en    <= 1'b0;
    end else begin
      count_q  <= count_n;
      op_q     <= op_n;
      neg_q    <= neg_n;
      acc_q    <= acc_n;
      mcand_q  <= mcand_n;
      mplier_q <= mplier_n;
      rem_q    <= rem_n;
      quo_q    <= quo_n;
      dvsr_q   <= dvsr_n;
      result   <= result_n;
      rd_out   <= rd_n;
      busy     <= busy_n;
      done     <= done_n;
      wb_en    <= wb_en_n;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed, table-driven bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        wb_en;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  muldiv_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_in    (rd_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .rd_out   (rd_out),
    .wb_en    (wb_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    bit          fast;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one operation and watch it to completion; optionally poke start mid-flight.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input bit fast, input bit poke);
    int lat, busy_n, done_n, wb_n;
    logic [31:0] res;
    logic [4:0]  rdo;
    lat = -1; busy_n = 0; done_n = 0; wb_n = 0; res = '0; rdo = '0;
    @(negedge clk);
    start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_in = rd;
    @(posedge clk);
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      // operands are don't-care after the start cycle
      start = poke && (cyc == 3 || cyc == 20);
      op = MULHU; rs1_data = 32'hDEAD_BEEF; rs2_data = 32'h1234_5678; rd_in = 5'd9;
      if (busy) busy_n++;
      if (wb_en) wb_n++;
      if (done) begin
        done_n++;
        if (lat < 0) begin
          lat = cyc; res = result; rdo = rd_out;
        end
      end
      if (!poke && lat >= 0 && cyc >= lat + 2) break;
    end
    start = 1'b0;
    chk({name, " result"}, res, exp);
    chk({name, " latency"}, 32'(lat), fast ? 32'd0 : 32'd32);
    chk({name, " busy_cycles"}, 32'(busy_n), fast ? 32'd1 : 32'd33);
    chk({name, " done_pulses"}, 32'(done_n), 32'd1);
    chk({name, " wb_pulses"}, 32'(wb_n), (rd != 5'd0) ? 32'd1 : 32'd0);
    chk({name, " rd_out"}, 32'(rdo), 32'(rd));
    chk({name, " idle_after"}, {29'd0, busy, done, wb_en}, 32'd0);
  endtask

  initial begin
    vecs.push_back('{"mul_7_m3",     MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0});
    vecs.push_back('{"mulh_min_min", MULH,   32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 1'b0});
    vecs.push_back('{"mulhu_ff_ff",  MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 1'b0});
    vecs.push_back('{"mulhsu_ff_ff", MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{"mulh_m1_1",    MULH,   32'hFFFF_FFFF,  32'd1,         5'd3,  32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{"mul_rd0",      MUL,    32'd3,          32'd4,         5'd0,  32'd12,        1'b0});
    vecs.push_back('{"div_m7_2",     DIV,    32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{"rem_m7_2",     REM,    32'hFFFF_FFF9,  32'd2,         5'd11, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{"divu_100_7",   DIVU,   32'd100,        32'd7,         5'd12, 32'd14,        1'b0});
    vecs.push_back('{"remu_100_7",   REMU,   32'd100,        32'd7,         5'd13, 32'd2,         1'b0});
    vecs.push_back('{"div_7_m2",     DIV,    32'd7,          32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{"rem_7_m2",     REM,    32'd7,          32'hFFFF_FFFE, 5'd15, 32'd1,         1'b0});
    vecs.push_back('{"divu_min_ff",  DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'd0,         1'b0});
    vecs.push_back('{"remu_min_ff",  REMU,   32'h8000_0000,  32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 1'b0});
    vecs.push_back('{"div_5_0",      DIV,    32'd5,          32'd0,         5'd18, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{"remu_5_0",     REMU,   32'd5,          32'd0,         5'd19, 32'd5,         1'b1});
    vecs.push_back('{"div_ovf",      DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd20, 32'h8000_0000, 1'b1});
    vecs.push_back('{"rem_ovf",      REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd21, 32'd0,         1'b1});
    vecs.push_back('{"divu_ff_1",    DIVU,   32'hFFFF_FFFF,  32'd1,         5'd22, 32'hFFFF_FFFF, 1'b0});

    start = 1'b0; op = '0; rs1_data = '0; rs2_data = '0; rd_in = '0;
    rst_n = 1'b1;
    #1;
    chk("reset_outputs", {26'd0, busy, done, wb_en, 3'd0}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_rd_out", 32'(rd_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].fast, 1'b0);

    // start pulses mid-operation must be ignored
    run_op("ignore_start", DIVU, 32'd1000, 32'd10, 5'd4, 32'd100, 1'b0, 1'b1);

    // reset abort during a divide
    begin
      int done_seen;
      done_seen = 0;
      @(negedge clk);
      start = 1'b1; op = DIVU; rs1_data = 32'd1000; rs2_data = 32'd3; rd_in = 5'd7;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      chk("abort_busy_before", 32'(busy), 32'd1);
      #1 rst_n = 1'b1;
      #1;
      chk("abort_flags", {29'd0, busy, done, wb_en}, 32'd0);
      chk("abort_result", result, 32'd0);
      chk("abort_rd_out", 32'(rd_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (done || wb_en || busy) done_seen++;
      end
      chk("abort_no_done", 32'(done_seen), 32'd0);
    end

    run_op("after_abort_divu_9_3", DIVU, 32'd9, 32'd3, 5'd7, 32'd3, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit for the single-cycle CPU. Sits between the register file read ports (consumes rs1/rs2 operands) and the register file write port (produces write data, destination and write enable). While it is busy it stalls the core. Latency is fixed: 32 iterations per operation, or 1 cycle for the divide special cases.

## Interface
- No parameters; data width fixed at 32.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-high reset (asserted = 1).
- `start`  in  1  request. Sampled only in IDLE.
- `op`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_data`  in  32  dividend or multiplicand (register read port 1).
- `rs2_data`  in  32  divisor or multiplier (register read port 2).
- `rd_in`  in  5  destination register index.
- `busy`  out  1  high whenever state != IDLE. The core stalls on busy.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  32  registered result. Holds its value until the next done.
- `rd_out`  out  5  latched destination, for the register file write index.
- `wb_en`  out  1  register file write enable. Equals done AND (rd_out != 0).

## Operation
- States: IDLE, CALC, DONE.
- **IDLE + start:**
  - Latch op, rd_in, and operand magnitudes. Take abs() of an operand only when it is signed and negative:
    - MULH: rs1 and rs2 signed.
    - MULHSU: rs1 signed only.
    - DIV, REM: both signed.
    - Others: unsigned.
  - Latch the result-sign flag:
    - Multiply and quotient: XOR of the effective operand signs.
    - Remainder: sign of the dividend.
  - Go to CALC with count = 0.
- **Fast path (IDLE -> DONE directly):**
  - Divide by zero (rs2 = 0):
    - DIV/DIVU: result = 0xFFFFFFFF.
    - REM/REMU: result = rs1_data.
  - Signed overflow (DIV/REM with rs1 = 0x80000000, rs2 = 0xFFFFFFFF):
    - DIV: result = 0x80000000.
    - REM: result = 0.
- **CALC, multiply:** shift-add. One multiplier bit per cycle into a 64-bit accumulator.
- **CALC, divide:** restoring division. One quotient bit per cycle. 33-bit partial remainder, trial subtract, 32-bit quotient register.
- **CALC exit:** after 32 iterations (count = 31 processed), go to DONE. On that transition:
  - Apply two's-complement negation if the sign flag is set.
  - Select the field: MUL = low 32 bits; MULH/MULHSU/MULHU = high 32 bits; DIV/DIVU = quotient; REM/REMU = remainder.
  - Register the selected value into `result`.
- **DONE:** assert done (and wb_en when rd_out != 0) for one cycle, then return to IDLE.
- start is ignored in CALC and DONE. No queuing.
- Operand inputs are don't-care after the start cycle.
- Reset values: state IDLE, busy 0, done 0, wb_en 0, result 0, rd_out 0, count 0, all datapath registers 0.

## Timing
- Let E0 be the rising edge that samples start.
- **Normal path:**
  - CALC iterations occur on E1..E32.
  - State = DONE after E32; done and wb_en are high for the cycle between E32 and E33.
  - IDLE after E33; the earliest next start is sampled at E34.
  - busy is high from after E0 until E33.
- **Fast path:** DONE after E0, done high for the cycle E0–E1, IDLE after E1.
- **Reset:** rst_n asserted mid-operation forces IDLE and clears all outputs immediately, without waiting for a clock. No done or wb_en pulse is emitted for the aborted operation.
- result, rd_out and wb_en change only on clk edges (or on reset).

## Test plan
- **MUL:** rs1 = 7, rs2 = 0xFFFFFFFD, rd = 5 -> after 32 cycles, done = 1, result = 0xFFFFFFEB, rd_out = 5, wb_en high for exactly 1 cycle. busy is high for 33 cycles.
- **High products:**
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- **Divide signs:**
  - DIV −7/2 -> 0xFFFFFFFD.
  - REM −7%2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14.
  - REMU 100%7 -> 2.
  - DIV 7/−2 -> 0xFFFFFFFD.
- **Special cases (each: done 1 cycle after start, busy for 1 cycle):**
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0.
- **Handshake:**
  - Start pulses at cycles 3 and 20 of an operation are ignored. Exactly one done is produced, with the first operation's result.
  - rd = 0: done pulses, wb_en stays 0.
- **Reset abort:**
  - Assert rst_n at iteration 10 of a DIVU -> busy, done, wb_en, result and rd_out are all 0 at once, and no done pulse follows.
  - Deassert, then start DIVU 9/3 -> result 3 after 32 cycles.
